// File: rtl/bus_pkg.sv
// Shared types for the byte-wide bus initiator: bus widths, the sequencer
// state encoding and the queued request record.
package bus_pkg;

  localparam int unsigned ADDR_W = 8;
  localparam int unsigned DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    RWAIT
  } state_t;

  typedef struct packed {
    logic              wen;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } req_t;

endpackage

// File: rtl/req_fifo.sv
// Synchronous request FIFO with wrap-around pointers carrying an extra lap bit.
// A push on a full FIFO is taken only when a pop happens in the same cycle.
module req_fifo
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  req_t push_data,
  input  logic pop,
  output req_t pop_data,
  output logic full,
  output logic empty
);

  localparam int unsigned PW = $clog2(DEPTH);

  req_t          mem [DEPTH];
  logic [PW:0]   wr_ptr;
  logic [PW:0]   rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign pop_data = mem[rd_ptr[PW-1:0]];
  assign do_pop   = pop && !empty;
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + (PW+1)'(1);
      if (do_pop)  rd_ptr <= rd_ptr + (PW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[PW-1:0]] <= push_data;
  end

endmodule

// File: rtl/bus_initiator.sv
// Host-to-chip bus initiator: queues byte read/write requests and plays them
// onto a strobe bus in order, capturing read data after a fixed latency.
module bus_initiator
  import bus_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned READ_LAT   = 1
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wen,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              valid,
  output logic              wen,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] wdata,
  input  logic [DATA_W-1:0] rdata
);

  state_t     state;
  logic [2:0] cnt;

  req_t new_req;
  req_t fifo_head;
  req_t head;
  logic fifo_full;
  logic fifo_empty;
  logic fifo_push;
  logic fifo_pop;
  logic can_take;
  logic accept;
  logic head_avail;
  logic take;
  logic bypass;

  assign new_req = '{wen: req_wen, addr: req_addr, wdata: req_wdata};

  // Sequencer is ready for a new head: idle, finishing a write, or on the
  // last wait cycle of a read.
  always_comb begin
    can_take = 1'b0;
    unique case (state)
      IDLE:    can_take = 1'b1;
      ISSUE:   can_take = wen;
      RWAIT:   can_take = (cnt == 3'd1);
      default: can_take = 1'b0;
    endcase
  end

  // An empty FIFO lets the incoming request straight through to the bus
  // registers so it appears on the pins the cycle after acceptance.
  assign req_ready  = !fifo_full || can_take;
  assign accept     = req_valid && req_ready;
  assign head_avail = !fifo_empty || accept;
  assign take       = can_take && head_avail;
  assign bypass     = fifo_empty && take;
  assign head       = fifo_empty ? new_req : fifo_head;
  assign fifo_push  = accept && !bypass;
  assign fifo_pop   = take && !fifo_empty;
  assign busy       = !fifo_empty || (state != IDLE);

  req_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (fifo_push),
    .push_data (new_req),
    .pop       (fifo_pop),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= 1'b0;
      wen       <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      valid     <= 1'b0;
      wen       <= 1'b0;
      rsp_valid <= 1'b0;
      if (take) begin
        valid <= 1'b1;
        wen   <= head.wen;
        addr  <= head.addr;
        wdata <= head.wdata;
      end
      unique case (state)
        IDLE: begin
          if (take) state <= ISSUE;
        end
        ISSUE: begin
          if (!wen) begin
            state <= RWAIT;
            cnt   <= 3'(READ_LAT);
          end else if (!take) begin
            state <= IDLE;
          end
        end
        RWAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) begin
            rsp_valid <= 1'b1;
            rsp_data  <= rdata;
            state     <= take ? ISSUE : IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/bus_initiator.md
BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, meaning request FIFO entries (power of two, at least 2).
REQ-002 Parameter READ_LAT, default 1, meaning cycles from the valid cycle to the cycle in which the responder's rdata is valid (1..7).
REQ-003 clk  in  1  single clock; all logic rising-edge.
REQ-004 resetn  in  1  asynchronous, active-low reset.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  request FIFO not full.
REQ-007 req_wen  in  1  1=write, 0=read.
REQ-008 req_addr  in  8  target byte address.
REQ-009 req_wdata  in  8  write byte; ignored for reads.
REQ-010 rsp_valid  out  1  one-cycle pulse: rsp_data holds read result.
REQ-011 rsp_data  out  8  captured read byte.
REQ-012 busy  out  1  FIFO non-empty or state not IDLE.
REQ-013 valid  out  1  bus strobe to chip pins.
REQ-014 wen  out  1  bus write enable.
REQ-015 addr  out  8  bus address.
REQ-016 wdata  out  8  bus write data.
REQ-017 rdata  in  8  bus read data from chip.

Function
REQ-018 Request accepted in a cycle with req_valid=1 and req_ready=1; {wen,addr,wdata} pushed to FIFO tail.
REQ-019 req_ready=0 when FIFO holds FIFO_DEPTH entries; requests offered while full are not accepted and not lost (host holds them).
REQ-020 Push and pop in the same cycle on a full FIFO: pop first, so req_ready is 1 in that cycle and the push is accepted.
REQ-021 States: IDLE, ISSUE, RWAIT.
REQ-022 IDLE -> ISSUE when FIFO non-empty; head popped, bus outputs registered from it.
REQ-023 ISSUE lasts exactly one cycle with valid=1 and wen/addr/wdata stable from head entry.
REQ-024 ISSUE (write): next state ISSUE if FIFO non-empty (back-to-back writes, valid high on consecutive cycles), else IDLE.
REQ-025 ISSUE (read): next state RWAIT; 3-bit counter loaded to READ_LAT.
REQ-026 RWAIT: valid=0; counter decrements each cycle; rdata sampled into rsp_data at the end of cycle k+READ_LAT, where k is the valid cycle.
REQ-027 rsp_valid=1 in cycle k+READ_LAT+1 only; rsp_data holds until the next read capture.
REQ-028 Leaving RWAIT: to ISSUE if FIFO non-empty, else IDLE; next valid no earlier than cycle k+READ_LAT+1.
REQ-029 Latency: request accepted in cycle n into empty FIFO while IDLE: valid=1 in cycle n+1.
REQ-030 Outside ISSUE: valid=0, wen=0; addr and wdata hold their last value.
REQ-031 Transactions issue in strict FIFO order; no reordering, no merging.
REQ-032 No response backpressure: rsp_valid pulses regardless of the host.

Reset
REQ-033 resetn=0 asynchronously forces: state IDLE, FIFO empty, valid=0, wen=0, addr=0, wdata=0, rsp_valid=0, rsp_data=0, busy=0, counter=0.
REQ-034 Reset during ISSUE or RWAIT aborts the transaction: no rsp_valid pulse, and queued entries are discarded.
REQ-035 After resetn rises, req_ready=1 in the first clock cycle.

Structure
REQ-036 Shared package bus_pkg holds ADDR_W=8, DATA_W=8, the state enum (IDLE/ISSUE/RWAIT), and the request struct {wen, addr, wdata}.
REQ-037 One sub-module, req_fifo: synchronous FIFO, FIFO_DEPTH entries, full/empty flags, wrap-around pointers with an extra bit.

Verification
REQ-038 Write A5 to 0x10 from IDLE, accepted in cycle n -> cycle n+1: valid=1, wen=1, addr=0x10, wdata=0xA5; cycle n+2: valid=0.
REQ-039 Four writes queued back-to-back -> valid high for 4 consecutive cycles, addresses in order; req_ready=0 after the fourth push with no pop.
REQ-040 Read 0x20 with READ_LAT=1, responder drives rdata=0x3C in cycle k+1 -> rsp_valid=1 in cycle k+2 with rsp_data=0x3C.
REQ-041 Read then write queued, READ_LAT=3 -> write valid no earlier than cycle k+4; exactly one rsp_valid pulse.
REQ-042 FIFO full while ISSUE pops and a new request is pushed in the same cycle -> push accepted and occupancy unchanged at 4.
REQ-043 resetn low during RWAIT with 2 entries queued -> valid=0 immediately, busy=0, no rsp_valid, and nothing issued after release.
